// File: rtl/asym_fifo_ctrl.sv
// asym_fifo_ctrl: pointer, flag and enable sequencer that turns a simple-dual-port
// asymmetric BRAM (narrow write port, wide read port) into a width-converting FIFO.
// Occupancy is tracked in narrow-word units; a wide word becomes poppable only
// once all R of its lanes have been written.
// Optional build macro: ASYM_FIFO_CTRL_ERR_FLAGS_EN adds sticky overflow/underflow flags.
module asym_fifo_ctrl #(
   parameter int C_RAM_WR_WIDTH = 16,
   parameter int C_RAM_RD_WIDTH = 32,
   parameter int C_RAM_RD_DEPTH = 1024,
   parameter int C_RD_LATENCY   = 3,
   parameter int C_AFULL_THRESH = C_RAM_RD_DEPTH * (C_RAM_RD_WIDTH / C_RAM_WR_WIDTH) - 4
) (
   input  logic                                                                  clk,
   input  logic                                                                  rst,
   input  logic                                                                  flush,
   input  logic                                                                  push,
   input  logic                                                                  pop,
   output logic                                                                  full,
   output logic                                                                  empty,
   output logic                                                                  almost_full,
   output logic [15:0]                                                           count,
   output logic [$clog2(C_RAM_RD_DEPTH * (C_RAM_RD_WIDTH / C_RAM_WR_WIDTH))-1:0] ram_wrAddr,
   output logic                                                                  ram_wren,
   output logic [$clog2(C_RAM_RD_DEPTH)-1:0]                                     ram_rdAddr,
   output logic                                                                  ram_rden,
   output logic                                                                  ram_rd_mode,
   output logic                                                                  ram_fifo_fwft,
   output logic                                                                  rd_data_vld,
   output logic                                                                  ovf_err,
   output logic                                                                  udf_err,
   input  logic                                                                  err_clr
);

   localparam int R     = C_RAM_RD_WIDTH / C_RAM_WR_WIDTH;
   localparam int LOG2R = $clog2(R);
   localparam int WD    = C_RAM_RD_DEPTH * R;
   localparam int WA    = $clog2(WD);
   localparam int RA    = $clog2(C_RAM_RD_DEPTH);

   localparam logic [WA:0] WD_W    = (WA+1)'(WD);
   localparam logic [WA:0] R_W     = (WA+1)'(R);
   localparam logic [WA:0] AFULL_W = (WA+1)'(C_AFULL_THRESH);

   // Pointers carry one extra MSB so that occ == WD is distinguishable from occ == 0.
   logic [WA:0] wr_ptr_reg, wr_ptr_next;
   logic [RA:0] rd_ptr_reg, rd_ptr_next;
   logic [WA:0] occ_next;
   logic        accepted_push;
   logic        accepted_pop;

   // Requests arriving together with flush are dropped; the flags are from the start of the cycle.
   assign accepted_push = push & ~full & ~flush;
   assign accepted_pop  = pop & ~empty & ~flush;

   // Next-pointer selection: flush clears both, otherwise each advances on its own accept.
   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      if (flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
      end else begin
         if (accepted_push) wr_ptr_next = wr_ptr_reg + (WA+1)'(1);
         if (accepted_pop)  rd_ptr_next = rd_ptr_reg + (RA+1)'(1);
      end
   end

   // Read pointer scaled to narrow-word units; modular subtraction gives 0..WD.
   assign occ_next = wr_ptr_next - {rd_ptr_next, {LOG2R{1'b0}}};

   // Pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
      end
   end

   // Status flags are registered from the next occupancy so they describe the current state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full        <= 1'b0;
         empty       <= 1'b1;
         almost_full <= 1'b0;
         count       <= '0;
      end else begin
         full        <= (occ_next == WD_W);
         empty       <= (occ_next < R_W);
         almost_full <= (occ_next >= AFULL_W);
         count       <= 16'(occ_next >> LOG2R);
      end
   end

   // The RAM picks the write lane from the low LOG2R address bits.
   assign ram_wren      = accepted_push;
   assign ram_wrAddr    = wr_ptr_reg[WA-1:0];
   assign ram_rdAddr    = rd_ptr_reg[RA-1:0];
   assign ram_rd_mode   = 1'b1;
   assign ram_fifo_fwft = 1'b0;

   generate
      if (C_RD_LATENCY == 0) begin : g_comb_rd
         assign ram_rden    = accepted_pop;
         assign rd_data_vld = accepted_pop;
      end else begin : g_pipe_rd
         logic                    rden_reg;
         logic [C_RD_LATENCY-1:0] vld_sr_reg;

         // Read enable free-runs from the first cycle after reset to keep the RAM pipeline moving.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) rden_reg <= 1'b0;
            else     rden_reg <= 1'b1;
         end

         // Accepted pops travel alongside the RAM read pipeline; flush discards them.
         always_ff @(posedge clk or posedge rst) begin
            if (rst)        vld_sr_reg <= '0;
            else if (flush) vld_sr_reg <= '0;
            else            vld_sr_reg <= {vld_sr_reg[C_RD_LATENCY-2:0], accepted_pop};
         end

         assign ram_rden    = rden_reg;
         assign rd_data_vld = vld_sr_reg[C_RD_LATENCY-1];
      end
   endgenerate

`ifdef ASYM_FIFO_CTRL_ERR_FLAGS_EN
   logic ovf_reg;
   logic udf_reg;

   // Sticky overflow: a new violation takes priority over a clear in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)              ovf_reg <= 1'b0;
      else if (push & full) ovf_reg <= 1'b1;
      else if (err_clr)     ovf_reg <= 1'b0;
   end

   // Sticky underflow with the same set-over-clear priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)              udf_reg <= 1'b0;
      else if (pop & empty) udf_reg <= 1'b1;
      else if (err_clr)     udf_reg <= 1'b0;
   end

   assign ovf_err = ovf_reg;
   assign udf_err = udf_reg;
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign ovf_err        = 1'b0;
   assign udf_err        = 1'b0;
`endif

endmodule

// File: tb/tb_asym_fifo_ctrl.sv
// tb_asym_fifo_ctrl: randomized and directed scenarios against a queue-based model of
// a 16->32 bit FIFO (R=2, 16 wide words, read latency 3), with a behavioural
// asymmetric RAM attached so popped data can be checked end to end.
module tb_asym_fifo_ctrl;

   localparam int R  = 2;
   localparam int WD = 32;
   localparam int AF = WD - 4;

   logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, push = 1'b0, pop = 1'b0, err_clr = 1'b0;
   logic        full, empty, almost_full, ram_wren, ram_rden, ram_rd_mode, ram_fifo_fwft;
   logic        rd_data_vld, ovf_err, udf_err;
   logic [15:0] count;
   logic [4:0]  ram_wrAddr;
   logic [3:0]  ram_rdAddr;

   always #5 clk = ~clk;

   asym_fifo_ctrl #(
      .C_RAM_WR_WIDTH(16), .C_RAM_RD_WIDTH(32), .C_RAM_RD_DEPTH(16), .C_RD_LATENCY(3)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush), .push(push), .pop(pop),
      .full(full), .empty(empty), .almost_full(almost_full), .count(count),
      .ram_wrAddr(ram_wrAddr), .ram_wren(ram_wren), .ram_rdAddr(ram_rdAddr), .ram_rden(ram_rden),
      .ram_rd_mode(ram_rd_mode), .ram_fifo_fwft(ram_fifo_fwft), .rd_data_vld(rd_data_vld),
      .ovf_err(ovf_err), .udf_err(udf_err), .err_clr(err_clr)
   );

   // Behavioural asymmetric RAM: narrow write lanes, wide 3-stage registered read.
   logic [15:0] wr_data = '0;
   logic [15:0] mem [0:WD-1];
   logic [31:0] p1, p2, p3;
   always @(posedge clk) begin
      if (ram_wren) mem[ram_wrAddr] <= wr_data;
      if (ram_rden) begin
         p1 <= {mem[{ram_rdAddr, 1'b1}], mem[{ram_rdAddr, 1'b0}]};
         p2 <= p1;
         p3 <= p2;
      end
   end

   // Reference model state: stored narrow words, expected strobes, write/read positions.
   typedef struct { int due; logic [31:0] data; } pend_t;
   logic [15:0] q[$];
   pend_t       pend[$];
   int          waddr = 0, raddr = 0, cyc = 0, since_rst = 0, vld_seen = 0;
   int          n_checks = 0, n_pass = 0;
   bit          pred_valid = 0, e_full, e_empty, e_af, e_push, e_pop, ovf_m = 0, udf_m = 0;
   int          e_count, e_cyc;
   logic [4:0]  last_wraddr;
   logic        last_wren;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or posedge rst) begin
      if (rst)                since_rst <= 0;
      else if (since_rst < 2) since_rst <= since_rst + 1;
   end

   // One clock of stimulus: predict this cycle's outputs, then apply the FIFO rules to the model.
   task automatic step(input bit p, input bit o, input bit f, input logic [15:0] d);
      pend_t pe;
      @(negedge clk);
      push = p; pop = o; flush = f; wr_data = d;
      #1;
      e_full  = (q.size() == WD);
      e_empty = (q.size() < R);
      e_af    = (q.size() >= AF);
      e_count = q.size() / R;
      e_push  = p && !e_full && !f;
      e_pop   = o && !e_empty && !f;
      e_cyc   = cyc;
      last_wraddr = ram_wrAddr;
      last_wren   = ram_wren;
      pred_valid  = 1;
      @(posedge clk);
      pred_valid = 0;
      if (p && e_full) ovf_m = 1;
      if (o && e_empty) udf_m = 1;
      if (f) begin
         q.delete(); pend.delete(); waddr = 0; raddr = 0;
      end else begin
         if (e_pop) begin
            pe.due = e_cyc + 3; pe.data = {q[1], q[0]};
            pend.push_back(pe);
            void'(q.pop_front()); void'(q.pop_front());
            raddr = (raddr + 1) % (WD / R);
         end
         if (e_push) begin
            q.push_back(d);
            waddr = (waddr + 1) % WD;
         end
      end
      #1;
      push = 0; pop = 0; flush = 0;
   endtask

   // Per-cycle scoreboard: flags, RAM control pins, strobe timing and popped data.
   always @(negedge clk) begin
      bit exp_v, x_ovf, x_udf;
      #2;
      if (pred_valid) begin
         x_ovf = 0; x_udf = 0;
`ifdef ASYM_FIFO_CTRL_ERR_FLAGS_EN
         x_ovf = ovf_m; x_udf = udf_m;
`endif
         exp_v = (pend.size() > 0) && (pend[0].due == cyc);
         n_checks++; if (full !== e_full) $display("FAIL full: got %0b want %0b cyc %0d", full, e_full, cyc); else n_pass++;
         n_checks++; if (empty !== e_empty) $display("FAIL empty: got %0b want %0b cyc %0d", empty, e_empty, cyc); else n_pass++;
         n_checks++; if (almost_full !== e_af) $display("FAIL almost_full: got %0b want %0b cyc %0d", almost_full, e_af, cyc); else n_pass++;
         n_checks++; if (count !== 16'(e_count)) $display("FAIL count: got %0d want %0d cyc %0d", count, e_count, cyc); else n_pass++;
         n_checks++; if (ram_wren !== e_push) $display("FAIL ram_wren: got %0b want %0b cyc %0d", ram_wren, e_push, cyc); else n_pass++;
         if (e_push) begin
            n_checks++; if (ram_wrAddr !== 5'(waddr)) $display("FAIL ram_wrAddr: got %0d want %0d cyc %0d", ram_wrAddr, waddr, cyc); else n_pass++;
         end
         if (e_pop) begin
            n_checks++; if (ram_rdAddr !== 4'(raddr)) $display("FAIL ram_rdAddr: got %0d want %0d cyc %0d", ram_rdAddr, raddr, cyc); else n_pass++;
         end
         n_checks++; if (ram_rden !== (since_rst >= 1)) $display("FAIL ram_rden: got %0b want %0b cyc %0d", ram_rden, since_rst >= 1, cyc); else n_pass++;
         n_checks++; if ({ram_rd_mode, ram_fifo_fwft} !== 2'b10) $display("FAIL mode_pins: got %b want 10", {ram_rd_mode, ram_fifo_fwft}); else n_pass++;
         n_checks++; if (ovf_err !== x_ovf) $display("FAIL ovf_err: got %0b want %0b cyc %0d", ovf_err, x_ovf, cyc); else n_pass++;
         n_checks++; if (udf_err !== x_udf) $display("FAIL udf_err: got %0b want %0b cyc %0d", udf_err, x_udf, cyc); else n_pass++;
         n_checks++; if (rd_data_vld !== exp_v) $display("FAIL rd_data_vld: got %0b want %0b cyc %0d", rd_data_vld, exp_v, cyc); else n_pass++;
         if (rd_data_vld === 1'b1) vld_seen++;
         if (exp_v) begin
            n_checks++; if (p3 !== pend[0].data) $display("FAIL rd_data: got %h want %h cyc %0d", p3, pend[0].data, cyc); else n_pass++;
            void'(pend.pop_front());
         end
      end
   end

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if ({empty, full, almost_full} !== 3'b100) $display("FAIL reset_flags: got %b want 100", {empty, full, almost_full}); else n_pass++;
      n_checks++; if (count !== 16'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
      n_checks++; if ({ram_wren, ram_rden, rd_data_vld} !== 3'b000) $display("FAIL reset_ctrl: got %b want 000", {ram_wren, ram_rden, rd_data_vld}); else n_pass++;
      n_checks++; if ({ovf_err, udf_err} !== 2'b00) $display("FAIL reset_err: got %b want 00", {ovf_err, udf_err}); else n_pass++;
      n_checks++; if ({ram_wrAddr, ram_rdAddr} !== 9'd0) $display("FAIL reset_addr: got %0d/%0d want 0/0", ram_wrAddr, ram_rdAddr); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      step(1, 0, 0, 16'h1111);
      step(1, 0, 0, 16'h2222);
      n_checks++; if (count !== 16'd1 || empty !== 1'b0) $display("FAIL basic_fill: got count %0d empty %0b want 1 0", count, empty); else n_pass++;
      step(0, 1, 0, 16'h0);
      step(0, 0, 0, 16'h0);
      step(0, 0, 0, 16'h0);
      n_checks++; if (rd_data_vld !== 1'b1 || p3 !== 32'h22221111) $display("FAIL basic_pop: got vld %0b data %h want 1 22221111", rd_data_vld, p3); else n_pass++;
      step(0, 0, 0, 16'h0);
   endtask

   task automatic test_full();
      bit want_ovf = 0;
`ifdef ASYM_FIFO_CTRL_ERR_FLAGS_EN
      want_ovf = 1;
`endif
      step(0, 0, 1, 16'h0);
      for (int i = 0; i < WD; i++) step(1, 0, 0, 16'($urandom));
      n_checks++; if ({full, almost_full} !== 2'b11 || count !== 16'd16) $display("FAIL full_flags: got full %0b af %0b count %0d want 1 1 16", full, almost_full, count); else n_pass++;
      step(1, 0, 0, 16'hdead);
      n_checks++; if (last_wren !== 1'b0 || full !== 1'b1) $display("FAIL full_reject: got wren %0b full %0b want 0 1", last_wren, full); else n_pass++;
      n_checks++; if (ovf_err !== want_ovf) $display("FAIL full_ovf: got %0b want %0b", ovf_err, want_ovf); else n_pass++;
      for (int i = 0; i < WD / R; i++) step(0, 1, 0, 16'h0);
      repeat (4) step(0, 0, 0, 16'h0);
      n_checks++; if (empty !== 1'b1) $display("FAIL full_drain: got empty %0b want 1", empty); else n_pass++;
   endtask

   task automatic test_partial_pop();
      step(0, 0, 1, 16'h0);
      vld_seen = 0;
      for (int i = 0; i < 3; i++) step(1, 0, 0, 16'($urandom));
      step(0, 1, 0, 16'h0);
      step(0, 1, 0, 16'h0);
      n_checks++; if (empty !== 1'b1 || count !== 16'd0) $display("FAIL partial_flags: got empty %0b count %0d want 1 0", empty, count); else n_pass++;
      repeat (4) step(0, 0, 0, 16'h0);
      n_checks++; if (vld_seen !== 1) $display("FAIL partial_strobes: got %0d want 1", vld_seen); else n_pass++;
   endtask

   task automatic test_wrap();
      logic [15:0] mx = '0;
      step(0, 0, 1, 16'h0);
      for (int i = 0; i < 31; i++) step(1, 0, 0, 16'($urandom));
      for (int i = 0; i < 130; i++) begin
         step(1, (i < 70) ? (i % 2 == 1) : (i % 3 == 2), 0, 16'($urandom));
         if (count > mx) mx = count;
      end
      n_checks++; if (mx > 16'd16 || mx < 16'd15) $display("FAIL wrap_count_max: got %0d want 15..16", mx); else n_pass++;
      for (int i = 0; i < 20; i++) step(0, 1, 0, 16'h0);
      repeat (4) step(0, 0, 0, 16'h0);
      n_checks++; if (empty !== 1'b1) $display("FAIL wrap_drain: got empty %0b want 1", empty); else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0), 16'($urandom));
      n_checks++; if (count !== 16'(q.size() / R)) $display("FAIL random_end_count: got %0d want %0d", count, q.size() / R); else n_pass++;
   endtask

   task automatic test_rst_midflight();
      step(0, 0, 1, 16'h0);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 16'($urandom));
      step(0, 1, 0, 16'h0);
      step(0, 1, 0, 16'h0);
      #2 rst = 1'b1;
      #1;
      n_checks++; if (rd_data_vld !== 1'b0) $display("FAIL rst_vld_drop: got %0b want 0", rd_data_vld); else n_pass++;
      n_checks++; if ({empty, full, almost_full, ram_rden} !== 4'b1000 || count !== 16'd0) $display("FAIL rst_flags: got %b count %0d want 1000 0", {empty, full, almost_full, ram_rden}, count); else n_pass++;
      n_checks++; if ({ovf_err, udf_err} !== 2'b00) $display("FAIL rst_err: got %b want 00", {ovf_err, udf_err}); else n_pass++;
      q.delete(); pend.delete(); waddr = 0; raddr = 0; ovf_m = 0; udf_m = 0;
      @(negedge clk);
      rst = 1'b0;
      step(1, 0, 0, 16'hA5A5);
      n_checks++; if (last_wraddr !== 5'd0 || last_wren !== 1'b1) $display("FAIL rst_restart_addr: got %0d wren %0b want 0 1", last_wraddr, last_wren); else n_pass++;
      step(1, 0, 0, 16'h5A5A);
      step(0, 1, 0, 16'h0);
      repeat (4) step(0, 0, 0, 16'h0);
   endtask

   task automatic test_flush_partial();
      step(0, 0, 1, 16'h0);
      for (int i = 0; i < 5; i++) step(1, 0, 0, 16'($urandom));
      step(1, 1, 1, 16'hFFFF);
      n_checks++; if (count !== 16'd0 || empty !== 1'b1) $display("FAIL flush_flags: got count %0d empty %0b want 0 1", count, empty); else n_pass++;
      step(1, 0, 0, 16'h0BEE);
      n_checks++; if (last_wraddr !== 5'd0) $display("FAIL flush_addr0: got %0d want 0", last_wraddr); else n_pass++;
      step(1, 0, 0, 16'hCAFE);
      n_checks++; if (last_wraddr !== 5'd1) $display("FAIL flush_addr1: got %0d want 1", last_wraddr); else n_pass++;
      step(0, 1, 0, 16'h0);
      repeat (4) step(0, 0, 0, 16'h0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_partial_pop();
      test_wrap();
      test_random();
      test_rst_midflight();
      test_flush_partial();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule

// File: doc/asym_fifo_ctrl.md
Name: asym_fifo_ctrl

Overview:
- Single-clock FIFO controller that sequences the simple-dual-port asymmetric-width BRAM (narrow write port, wide read port) as a width-converting FIFO.
- Owns the write and read pointers, drives the RAM's address and enable pins, and reports occupancy, full and empty.
- Produces a data-valid strobe aligned to the RAM's read latency.
- The RAM's wr_clk and rd_clk are both tied to this block's clk at the parent level.

Parameters:
- C_RAM_WR_WIDTH, 16: narrow write-word width in bits.
- C_RAM_RD_WIDTH, 32: wide read-word width. C_RAM_RD_WIDTH / C_RAM_WR_WIDTH = R, which must be a power of 2 and at least 2.
- C_RAM_RD_DEPTH, 1024: read-word depth, a power of 2. Write depth WD = C_RAM_RD_DEPTH * R.
- C_RD_LATENCY, 3: RAM read latency in cycles. Legal values are 3 (RAM in HIGH_PERFORMANCE mode) and 0 (RAM in combinational read mode).
- C_AFULL_THRESH, WD-4: almost_full threshold, in write words.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset; asynchronous, active-high.
- flush, in, 1: synchronous clear of the pointers.
- push, in, 1: write request, one narrow word per cycle.
- pop, in, 1: read request, one wide word per cycle.
- full, out, 1: no write space.
- empty, out, 1: fewer than R narrow words stored.
- almost_full, out, 1: occupancy >= C_AFULL_THRESH.
- count, out, 16: complete wide words stored.
- ram_wrAddr, out, clog2(WD): narrow write address to the RAM.
- ram_wren, out, 1: RAM write enable.
- ram_rdAddr, out, clog2(C_RAM_RD_DEPTH): wide read address to the RAM.
- ram_rden, out, 1: RAM read enable.
- ram_rd_mode, out, 1: RAM read-mode select; tied to 1.
- ram_fifo_fwft, out, 1: RAM first-word-fall-through select; tied to 0.
- rd_data_vld, out, 1: RAM dout carries the popped word this cycle.
- ovf_err, out, 1: sticky overflow flag (see Optional Feature).
- udf_err, out, 1: sticky underflow flag (see Optional Feature).
- err_clr, in, 1: clears ovf_err and udf_err (see Optional Feature).

Behaviour:
- Pointers:
  - wr_ptr is clog2(WD)+1 bits, in narrow-word units.
  - rd_ptr is clog2(C_RAM_RD_DEPTH)+1 bits, in wide-word units.
  - Both wrap naturally; the extra MSB distinguishes full from empty.
- Occupancy:
  - occ = wr_ptr - (rd_ptr << log2(R)), modulo 2^(clog2(WD)+1), range 0..WD.
  - full = (occ == WD).
  - empty = (occ < R).
  - almost_full = (occ >= C_AFULL_THRESH).
  - count = occ >> log2(R), zero-extended to 16 bits.
  - All four flags are registered and reflect the state at the start of the cycle.
- Write:
  - accepted_push = push & ~full.
  - ram_wren = accepted_push, combinational.
  - ram_wrAddr = wr_ptr[clog2(WD)-1:0]. The RAM selects the lane from the low log2(R) bits.
  - wr_ptr increments on an accepted push.
- Read:
  - accepted_pop = pop & ~empty.
  - ram_rdAddr = rd_ptr[low bits]; rd_ptr increments on an accepted pop.
  - C_RD_LATENCY=3: ram_rden is held at 1 from the first cycle after reset so the RAM's 3-stage pipeline free-runs. rd_data_vld is accepted_pop delayed through a 3-deep shift register.
  - C_RD_LATENCY=0: ram_rden = accepted_pop and rd_data_vld = accepted_pop in the same cycle.
- Simultaneous push and pop are both honoured in the same cycle; occ changes by +1-R.
- A wide word whose last lane is pushed in cycle t is poppable no earlier than t+1. There is no write-to-read bypass.
- Rejected requests:
  - push while full: no write, pointers unchanged.
  - pop while empty: no read, pointers unchanged, no valid strobe.
- Partial words: a partially filled wide word (occ mod R != 0) is never popped. flush discards it.
- flush:
  - Next cycle: wr_ptr=0, rd_ptr=0, empty=1, full=0, count=0.
  - Clears the rd_data_vld pipeline.
  - push and pop in the flush cycle are ignored.
- Reset values:
  - All pointers 0; empty=1; full=0; almost_full=0; count=0.
  - ram_wren=0, ram_rden=0, rd_data_vld=0, ovf_err=0, udf_err=0.
  - An asserted rst mid-transfer drops in-flight rd_data_vld strobes immediately. RAM contents are not cleared.

Optional Feature:
- Macro: ASYM_FIFO_CTRL_ERR_FLAGS_EN.
- Defined:
  - ovf_err sets on push & full.
  - udf_err sets on pop & empty.
  - Both stay set until err_clr=1 for one cycle. If set and clear coincide, set wins.
  - Both are cleared by rst.
- Undefined: ovf_err and udf_err are driven constant 0, err_clr is ignored, and no error registers are synthesized.

Test Plan (R=2, C_RAM_RD_DEPTH=16, WD=32, C_RD_LATENCY=3):
- Push 0x1111 then 0x2222 -> count=1 and empty=0 on the cycle after the 2nd push. Pop -> rd_data_vld 3 cycles later with RAM dout=0x22221111.
- Push 32 words with no pops -> full=1 after the 32nd. A 33rd push is rejected and ram_wren=0. With the feature enabled, ovf_err=1.
- Fill 3 narrow words, pop once, pop again -> first pop is accepted. Second pop is rejected because occ=1 < R. empty=1, count=0, no second valid strobe.
- Steady state with a push every cycle and a pop every 2nd cycle across the pointer wrap (more than 64 narrow words) -> data order is preserved, count never exceeds 16, and full/empty are correct at the wrap.
- Assert rst while 2 valid strobes are in flight -> rd_data_vld=0 immediately and all flags at their reset values. A subsequent push/pop sequence works from address 0.
- Partial word (occ=5) then flush -> next cycle count=0, empty=1. The next pushes write ram_wrAddr 0 and 1.
